// File: rtl/qfix_pkg.sv
// Shared sign-magnitude fixed-point definitions for the qsub datapath.
// Default format is Q15 in a 32-bit word: sign bit on top, 31-bit magnitude below.
package qfix_pkg;

    localparam int Q_DEF = 15;
    localparam int N_DEF = 32;
    localparam int MAG_W = N_DEF - 1;
    localparam logic [MAG_W-1:0] MAG_MAX = '1;

    typedef struct packed {
        logic             sign;
        logic [MAG_W-1:0] mag;
    } sm_word_t;

    // A zero magnitude never carries a sign, so -0 behaves exactly like +0.
    function automatic logic eff_sign(input logic sign, input logic mag_nz);
        return sign & mag_nz;
    endfunction

endpackage

// File: rtl/qsm_mag_unit.sv
// Combinational sign-magnitude add/subtract of two magnitudes with overflow flag.
// QSUB_SAT_EN defined: overflowing sums saturate to all ones; otherwise the carry is dropped.
import qfix_pkg::*;

module qsm_mag_unit #(
    parameter int W = MAG_W
) (
    input  logic [W-1:0] mag_a,
    input  logic [W-1:0] mag_b,
    input  logic         sign_a,
    input  logic         sign_b,
    input  logic         ge,
    input  logic         sub,
    output logic [W-1:0] mag_c,
    output logic         sign_c,
    output logic         ovf
);

    logic [W:0]   sum;
    logic [W-1:0] diff;
    logic         sign_raw;

    always_comb begin
        sum      = {1'b0, mag_a} + {1'b0, mag_b};
        diff     = ge ? (mag_a - mag_b) : (mag_b - mag_a);
        mag_c    = sum[W-1:0];
        sign_raw = sign_a;
        ovf      = 1'b0;
        if (sub) begin
            mag_c    = diff;
            sign_raw = ge ? sign_a : sign_b;
        end else begin
            ovf = sum[W];
`ifdef QSUB_SAT_EN
            if (sum[W]) begin
                mag_c = {W{1'b1}};
            end
`endif
        end
        sign_c = sign_raw & (|mag_c);
    end

endmodule

// File: rtl/qsub_pipe.sv
// Two-stage valid/ready sign-magnitude subtractor c = a - b in Q format.
// Build option QSUB_SAT_EN selects saturation instead of wrap on magnitude overflow.
import qfix_pkg::*;

module qsub_pipe #(
    parameter int Q = Q_DEF,
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         ovf
);

    localparam int W = N - 1;

    if (Q >= N) begin : g_q_check
        $error("qsub_pipe: Q must leave room for the sign bit");
    end

    logic         v1, v2;
    logic         adv1, adv2;
    logic [W-1:0] s1_mag_a, s1_mag_b;
    logic         s1_sign_a, s1_sign_b, s1_ge, s1_sub;

    logic [W-1:0] in_mag_a, in_mag_b;
    logic         in_sign_a, in_sign_b;

    logic [W-1:0] mag_c;
    logic         sign_c, ovf_c;

    assign adv2     = !v2 || out_ready;
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1;
    assign out_valid = v2;

    // Subtraction is addition of b with its sign flipped.
    assign in_mag_a  = a[W-1:0];
    assign in_mag_b  = b[W-1:0];
    assign in_sign_a = eff_sign(a[N-1], |in_mag_a);
    assign in_sign_b = eff_sign(~b[N-1], |in_mag_b);

    qsm_mag_unit #(.W(W)) u_mag (
        .mag_a  (s1_mag_a),
        .mag_b  (s1_mag_b),
        .sign_a (s1_sign_a),
        .sign_b (s1_sign_b),
        .ge     (s1_ge),
        .sub    (s1_sub),
        .mag_c  (mag_c),
        .sign_c (sign_c),
        .ovf    (ovf_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            s1_mag_a  <= '0;
            s1_mag_b  <= '0;
            s1_sign_a <= 1'b0;
            s1_sign_b <= 1'b0;
            s1_ge     <= 1'b0;
            s1_sub    <= 1'b0;
            c         <= '0;
            ovf       <= 1'b0;
        end else begin
            if (adv1) begin
                v1 <= in_valid;
            end
            if (adv1 && in_valid) begin
                s1_mag_a  <= in_mag_a;
                s1_mag_b  <= in_mag_b;
                s1_sign_a <= in_sign_a;
                s1_sign_b <= in_sign_b;
                s1_ge     <= (in_mag_a >= in_mag_b);
                s1_sub    <= in_sign_a ^ in_sign_b;
            end
            if (adv2) begin
                v2 <= v1;
            end
            if (adv2 && v1) begin
                c   <= {sign_c, mag_c};
                ovf <= ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_qsub_pipe.sv
// Scoreboard bench for qsub_pipe: directed corner cases, backpressure, reset flush, random traffic.
// Expected results come from a signed-integer model of a - b.
module tb_qsub_pipe;

    localparam int N  = 32;
    localparam int Q  = 15;
    localparam int MW = N - 1;
    localparam longint MAXM = (longint'(1) << MW) - 1;
`ifdef QSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         in_ready, out_valid, ovf;
    logic [N-1:0] c;

    qsub_pipe #(.Q(Q), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] c;
        logic         ovf;
        int           in_cyc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   strict_lat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y, input int t);
        exp_t   e;
        longint va, vb, r, m;
        va = longint'(x[MW-1:0]);
        if (x[N-1]) va = -va;
        vb = longint'(y[MW-1:0]);
        if (y[N-1]) vb = -vb;
        r = va - vb;
        m = (r < 0) ? -r : r;
        e.ovf = (m > MAXM);
        if (e.ovf) m = SAT ? MAXM : m - (longint'(1) << MW);
        e.c[N-1]    = (r < 0) && (m != 0);
        e.c[MW-1:0] = m[MW-1:0];
        e.in_cyc    = t;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: samples mid-cycle what the next rising edge will transfer.
    bit           held = 1'b0;
    logic [N-1:0] hc;
    logic         ho;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sbq.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_c", 64'(c), 64'(hc));
                check("hold_ovf", 64'(ovf), 64'(ho));
            end
            if (out_valid && !held && sbq.size() != 0) begin
                if (strict_lat) check("latency", 64'(cyc - sbq[0].in_cyc), 64'd2);
                else            check("latency_min", 64'(cyc - sbq[0].in_cyc >= 2), 64'd1);
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=%h required=none t=%0t", c, $time);
                end else begin
                    e = sbq.pop_front();
                    check("result_c", 64'(c), 64'(e.c));
                    check("result_ovf", 64'(ovf), 64'(e.ovf));
                end
            end
            held = out_valid && !out_ready;
            hc   = c;
            ho   = ovf;
            if (in_valid && in_ready) sbq.push_back(model(a, b, cyc));
        end
    end

    // Call just after a rising edge; leaves in_valid high once the pair is taken.
    task automatic push_op(input logic [N-1:0] xa, input logic [N-1:0] xb, output int waited);
        bit ok;
        in_valid = 1'b1;
        a        = xa;
        b        = xb;
        waited   = 0;
        while (1) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            waited++;
            if (ok) break;
            if (waited > 100) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout actual=%0d required=accept", waited);
                break;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain_empty", 64'(sbq.size()), 64'd0);
    endtask

    function automatic logic [N-1:0] rand_word();
        logic [N-1:0] w;
        w = $urandom;
        case ($urandom_range(0, 5))
            0: w[MW-1:0] = MW'($urandom_range(0, 3));
            1: w[MW-1:0] = '1 - MW'($urandom_range(0, 3));
            2: w[MW-1:0] = '0;
            3: w[MW-1:0] = MW'($urandom_range(0, 32'h0003_0000));
            default: ;
        endcase
        return w;
    endfunction

    int w;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_c", 64'(c), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        out_ready  = 1'b1;
        strict_lat = 1'b1;
        push_op(32'h0001_8000, 32'h0000_8000, w);
        check("first_accept_wait", 64'(w), 64'd1);
        push_op(32'h0000_8000, 32'h0001_8000, w);
        push_op(32'h8000_8000, 32'h8000_8000, w);
        push_op(32'h8000_0000, 32'h0000_0000, w);
        push_op(32'h7FFF_FFFF, 32'h8000_0001, w);
        push_op(32'hFFFF_FFFF, 32'h7FFF_FFFF, w);
        push_op(32'h0000_1234, 32'h8000_0000, w);
        drain();

        strict_lat = 1'b0;
        out_ready  = 1'b0;
        push_op(32'h0000_0001, 32'h0000_0002, w);
        check("bp_accept0_wait", 64'(w), 64'd1);
        push_op(32'h8000_0003, 32'h0000_0004, w);
        check("bp_accept1_wait", 64'(w), 64'd1);
        a = 32'h0000_0005;
        b = 32'h8000_0006;
        @(negedge clk);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push_op(32'h0000_0005, 32'h8000_0006, w);
        push_op(32'h8000_0007, 32'h8000_0007, w);
        drain();

        strict_lat = 1'b1;
        push_op(32'h0000_0100, 32'h0000_0001, w);
        push_op(32'h0000_0200, 32'h0000_0002, w);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_flush_out_valid", 64'(out_valid), 64'd0);
        check("rst_flush_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("no_stale_result", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        push_op(32'h0000_8000, 32'h8000_8000, w);
        check("post_rst_accept_wait", 64'(w), 64'd1);
        drain();

        strict_lat = 1'b0;
        for (int i = 0; i < 500; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            a         = rand_word();
            b         = rand_word();
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
